// File: rtl/memory_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// memory_arbiter_pkg : shared state encodings and constants for memory_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package memory_arbiter_pkg;

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_busy_i = 2'd1;
    localparam logic [1:0] c_busy_d = 2'd2;
    localparam logic [1:0] c_done   = 2'd3;

    localparam logic [3:0] c_sel_all = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter : shares one memory bus between fetch and data ports
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [31:0] imem_address_i,
    input  logic        imem_read_i,
    output logic [31:0] imem_data_o,
    output logic        imem_data_ready_o,
    input  logic [31:0] dmem_address_i,
    input  logic [31:0] dmem_data_i,
    input  logic [3:0]  dmem_sel_i,
    input  logic        dmem_read_i,
    input  logic        dmem_write_i,
    output logic [31:0] dmem_data_o,
    output logic        dmem_data_ready_o,
    output logic [31:0] bus_address_o,
    output logic [31:0] bus_data_o,
    output logic [3:0]  bus_sel_o,
    output logic        bus_read_o,
    output logic        bus_write_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i,
    output logic        timeout_o
);

    localparam int c_sw = $clog2(MAX_DSTREAK + 1);
    localparam int c_tw = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_sw-1:0] c_streak_max = c_sw'(MAX_DSTREAK);
    localparam logic [c_tw-1:0] c_timeout    = c_tw'(TIMEOUT);
    localparam bit              c_to_en      = (TIMEOUT != 0);

    logic [1:0]      r_state;
    logic [c_sw-1:0] r_streak;
    logic [c_tw-1:0] r_timer;

    logic w_dmem_req;
    logic w_imem_wins;
    logic w_busy;
    logic w_expire;
    logic w_finish;

    assign w_dmem_req  = dmem_read_i | dmem_write_i;
    assign w_imem_wins = imem_read_i && (!w_dmem_req || (r_streak == c_streak_max));
    assign w_busy      = (r_state == c_busy_i) || (r_state == c_busy_d);
    // Ack on the expiry cycle takes precedence over the abort
    assign w_expire    = c_to_en && w_busy && (r_timer == c_timeout) && !bus_ack_i;
    assign w_finish    = w_busy && (bus_ack_i || w_expire);

    assign imem_data_ready_o = (r_state == c_busy_i) && (bus_ack_i || w_expire);
    assign dmem_data_ready_o = (r_state == c_busy_d) && (bus_ack_i || w_expire);
    assign imem_data_o       = w_expire ? 32'h0 : bus_data_i;
    assign dmem_data_o       = w_expire ? 32'h0 : bus_data_i;
    assign timeout_o         = w_expire;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state       <= c_idle;
            r_streak      <= '0;
            r_timer       <= '0;
            bus_address_o <= '0;
            bus_data_o    <= '0;
            bus_sel_o     <= '0;
            bus_read_o    <= 1'b0;
            bus_write_o   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_timer <= c_tw'(1);
                    if (w_imem_wins) begin
                        bus_address_o <= imem_address_i;
                        bus_data_o    <= '0;
                        bus_sel_o     <= c_sel_all;
                        bus_read_o    <= 1'b1;
                        bus_write_o   <= 1'b0;
                        r_streak      <= '0;
                        r_state       <= c_busy_i;
                    end else if (w_dmem_req) begin
                        bus_address_o <= dmem_address_i;
                        bus_data_o    <= dmem_data_i;
                        bus_sel_o     <= dmem_sel_i;
                        bus_read_o    <= !dmem_write_i;
                        bus_write_o   <= dmem_write_i;
                        r_state       <= c_busy_d;
                        // Streak only matters while a fetch is waiting
                        if (!imem_read_i) begin
                            r_streak <= '0;
                        end else if (r_streak != c_streak_max) begin
                            r_streak <= r_streak + c_sw'(1);
                        end
                    end else begin
                        r_streak <= '0;
                    end
                end
                c_busy_i, c_busy_d: begin
                    if (w_finish) begin
                        bus_read_o  <= 1'b0;
                        bus_write_o <= 1'b0;
                        r_state     <= c_done;
                    end else begin
                        r_timer <= r_timer + c_tw'(1);
                    end
                end
                c_done: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter : directed self-checking bench for memory_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr = '0;
    logic        imem_read = 1'b0;
    logic [31:0] imem_data_o;
    logic        imem_ready;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic [3:0]  dmem_sel = '0;
    logic        dmem_read = 1'b0;
    logic        dmem_write = 1'b0;
    logic [31:0] dmem_data_o;
    logic        dmem_ready;
    logic [31:0] bus_address_o;
    logic [31:0] bus_data_o;
    logic [3:0]  bus_sel_o;
    logic        bus_read_o;
    logic        bus_write_o;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        timeout_o;

    int n_total = 0;
    int n_bad   = 0;

    memory_arbiter #(
        .MAX_DSTREAK(4),
        .TIMEOUT    (8)
    ) dut (
        .clock_i          (clk),
        .reset_n_i        (rst_n),
        .imem_address_i   (imem_addr),
        .imem_read_i      (imem_read),
        .imem_data_o      (imem_data_o),
        .imem_data_ready_o(imem_ready),
        .dmem_address_i   (dmem_addr),
        .dmem_data_i      (dmem_wdata),
        .dmem_sel_i       (dmem_sel),
        .dmem_read_i      (dmem_read),
        .dmem_write_i     (dmem_write),
        .dmem_data_o      (dmem_data_o),
        .dmem_data_ready_o(dmem_ready),
        .bus_address_o    (bus_address_o),
        .bus_data_o       (bus_data_o),
        .bus_sel_o        (bus_sel_o),
        .bus_read_o       (bus_read_o),
        .bus_write_o      (bus_write_o),
        .bus_data_i       (bus_rdata),
        .bus_ack_i        (bus_ack),
        .timeout_o        (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        tick();
        while (!(bus_read_o || bus_write_o) && n < 6) begin
            tick();
            n++;
        end
        check({tag, " strobe"}, 32'(bus_read_o | bus_write_o), 32'd1);
    endtask

    logic [31:0] exp_addr [6];

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_addr = '{32'h800, 32'h800, 32'h800, 32'h800, 32'h300, 32'h800};

        repeat (2) tick();
        check("rst bus_read",   32'(bus_read_o),  32'd0);
        check("rst bus_write",  32'(bus_write_o), 32'd0);
        check("rst bus_addr",   bus_address_o,    32'h0);
        check("rst bus_sel",    32'(bus_sel_o),   32'd0);
        check("rst timeout",    32'(timeout_o),   32'd0);
        check("rst imem_ready", 32'(imem_ready),  32'd0);
        check("rst dmem_ready", 32'(dmem_ready),  32'd0);
        rst_n = 1'b1;
        tick();

        // Lone fetch, two wait cycles
        imem_addr = 32'h100;
        imem_read = 1'b1;
        #1;
        check("t1 no early strobe", 32'(bus_read_o), 32'd0);
        tick();
        check("t1 bus_read",  32'(bus_read_o),  32'd1);
        check("t1 bus_write", 32'(bus_write_o), 32'd0);
        check("t1 bus_sel",   32'(bus_sel_o),   32'hF);
        check("t1 bus_addr",  bus_address_o,    32'h100);
        check("t1 wait1 ready", 32'(imem_ready), 32'd0);
        tick();
        check("t1 wait2 ready", 32'(imem_ready), 32'd0);
        tick();
        bus_rdata = 32'h1234_5678;
        bus_ack   = 1'b1;
        #1;
        check("t1 imem_ready", 32'(imem_ready), 32'd1);
        check("t1 imem_data",  imem_data_o,     32'h1234_5678);
        check("t1 dmem_ready", 32'(dmem_ready), 32'd0);
        tick();
        bus_ack   = 1'b0;
        imem_read = 1'b0;
        check("t1 strobe cleared", 32'(bus_read_o), 32'd0);
        tick();

        // Simultaneous requests: data port first
        imem_addr = 32'h200;
        imem_read = 1'b1;
        dmem_addr = 32'h400;
        dmem_sel  = 4'hF;
        dmem_read = 1'b1;
        tick();
        check("t2 first addr", bus_address_o,   32'h400);
        check("t2 first read", 32'(bus_read_o), 32'd1);
        bus_rdata = 32'hAAAA_5555;
        bus_ack   = 1'b1;
        #1;
        check("t2 dmem_ready", 32'(dmem_ready), 32'd1);
        check("t2 imem_idle",  32'(imem_ready), 32'd0);
        check("t2 dmem_data",  dmem_data_o,     32'hAAAA_5555);
        tick();
        bus_ack   = 1'b0;
        dmem_read = 1'b0;
        tick();
        tick();
        check("t2 second addr", bus_address_o,   32'h200);
        check("t2 second read", 32'(bus_read_o), 32'd1);
        check("t2 second sel",  32'(bus_sel_o),  32'hF);
        bus_rdata = 32'h0BAD_F00D;
        bus_ack   = 1'b1;
        #1;
        check("t2 imem_ready", 32'(imem_ready), 32'd1);
        check("t2 imem_data",  imem_data_o,     32'h0BAD_F00D);
        tick();
        bus_ack   = 1'b0;
        imem_read = 1'b0;
        tick();

        // Store stream with a held fetch: D D D D I D
        dmem_addr  = 32'h800;
        dmem_wdata = 32'h1111_2222;
        dmem_sel   = 4'hF;
        dmem_write = 1'b1;
        imem_addr  = 32'h300;
        imem_read  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_strobe($sformatf("t3 txn%0d", i));
            check($sformatf("t3 txn%0d addr", i), bus_address_o, exp_addr[i]);
            check($sformatf("t3 txn%0d write", i), 32'(bus_write_o), (i == 4) ? 32'd0 : 32'd1);
            bus_ack = 1'b1;
            #1;
            check($sformatf("t3 txn%0d owner", i),
                  {30'd0, imem_ready, dmem_ready}, (i == 4) ? 32'd2 : 32'd1);
            tick();
            bus_ack = 1'b0;
            if (i == 5) begin
                dmem_write = 1'b0;
                imem_read  = 1'b0;
            end
        end
        tick();

        // Partial-lane store
        dmem_addr  = 32'h10;
        dmem_wdata = 32'hCAFE_F00D;
        dmem_sel   = 4'b0011;
        dmem_write = 1'b1;
        tick();
        check("t4 bus_write", 32'(bus_write_o), 32'd1);
        check("t4 bus_read",  32'(bus_read_o),  32'd0);
        check("t4 bus_data",  bus_data_o,       32'hCAFE_F00D);
        check("t4 bus_sel",   32'(bus_sel_o),   32'h3);
        check("t4 bus_addr",  bus_address_o,    32'h10);
        tick();
        check("t4 bus_read later", 32'(bus_read_o), 32'd0);
        bus_ack = 1'b1;
        #1;
        check("t4 dmem_ready", 32'(dmem_ready), 32'd1);
        tick();
        bus_ack    = 1'b0;
        dmem_write = 1'b0;
        check("t4 write cleared", 32'(bus_write_o), 32'd0);
        tick();

        // Timeout after 8 BUSY cycles, then ack exactly on the expiry cycle
        dmem_addr = 32'h20;
        dmem_sel  = 4'hF;
        dmem_read = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        tick();
        repeat (6) tick();
        check("t5 cyc7 timeout", 32'(timeout_o),  32'd0);
        check("t5 cyc7 ready",   32'(dmem_ready), 32'd0);
        tick();
        check("t5 cyc8 timeout", 32'(timeout_o),  32'd1);
        check("t5 cyc8 ready",   32'(dmem_ready), 32'd1);
        check("t5 cyc8 data",    dmem_data_o,     32'h0);
        tick();
        check("t5 done timeout", 32'(timeout_o),  32'd0);
        check("t5 done strobe",  32'(bus_read_o), 32'd0);
        tick();
        check("t5 idle strobe",  32'(bus_read_o), 32'd0);
        tick();
        check("t5 regrant strobe", 32'(bus_read_o), 32'd1);
        repeat (7) tick();
        bus_rdata = 32'h5A5A_5A5A;
        bus_ack   = 1'b1;
        #1;
        check("t5 ackwin timeout", 32'(timeout_o),  32'd0);
        check("t5 ackwin ready",   32'(dmem_ready), 32'd1);
        check("t5 ackwin data",    dmem_data_o,     32'h5A5A_5A5A);
        tick();
        bus_ack   = 1'b0;
        dmem_read = 1'b0;
        tick();

        // Asynchronous reset while a load is on the bus
        dmem_addr = 32'h40;
        dmem_read = 1'b1;
        tick();
        check("t6 busy strobe", 32'(bus_read_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6 async strobe", 32'(bus_read_o), 32'd0);
        check("t6 async addr",   bus_address_o,   32'h0);
        check("t6 async ready",  32'(dmem_ready), 32'd0);
        dmem_read = 1'b0;
        tick();
        rst_n   = 1'b1;
        bus_ack = 1'b1;
        #1;
        check("t6 idle dmem_ready", 32'(dmem_ready), 32'd0);
        check("t6 idle imem_ready", 32'(imem_ready), 32'd0);
        tick();
        bus_ack   = 1'b0;
        imem_addr = 32'h500;
        imem_read = 1'b1;
        tick();
        check("t6 new strobe", 32'(bus_read_o), 32'd1);
        check("t6 new addr",   bus_address_o,   32'h500);
        bus_rdata = 32'h0000_0077;
        bus_ack   = 1'b1;
        #1;
        check("t6 new ready", 32'(imem_ready), 32'd1);
        tick();
        bus_ack   = 1'b0;
        imem_read = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
